tamagotchi_fsm: RTL and testbench

TAMAGOTCHI_FSM -- requirements
Module: tamagotchi_fsm

---
 rtl/tamagotchi_fsm_pkg.sv | 46 ++++
 rtl/seg7_decoder.sv | 24 ++
 rtl/tamagotchi_fsm.sv | 114 +++++++++++
 tb/tb_tamagotchi_fsm.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/tamagotchi_fsm_pkg.sv
// rtl/tamagotchi_fsm_pkg.sv - shared encodings, limits and level helpers for tamagotchi_fsm
// Contents: FSM state enum, stat indices, level limits, one-hot display codes,
// active-low 7-segment patterns {g,f,e,d,c,b,a}, saturating level update helper.
package tamagotchi_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SALUD     = 3'd1,
    ST_ENERGIA   = 3'd2,
    ST_HAMBRE    = 3'd3,
    ST_DIVERSION = 3'd4
  } state_e;

  localparam logic [2:0] MAX_LEVEL   = 3'd5;
  localparam logic [2:0] RESET_LEVEL = 3'd3;

  localparam logic [3:0] DISP_IDLE      = 4'b0000;
  localparam logic [3:0] DISP_SALUD     = 4'b0001;
  localparam logic [3:0] DISP_ENERGIA   = 4'b0010;
  localparam logic [3:0] DISP_HAMBRE    = 4'b0100;
  localparam logic [3:0] DISP_DIVERSION = 4'b1000;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // A press always wins over a tick on the same stat; a tick normally
  // decays the level, but 'rise' turns it into a recovery step.
  function automatic logic [2:0] next_level(input logic [2:0] cur,
                                            input logic       pressed,
                                            input logic       tick,
                                            input logic       rise);
    logic [2:0] up;
    logic [2:0] down;
    up   = (cur >= MAX_LEVEL) ? MAX_LEVEL : cur + 3'd1;
    down = (cur == 3'd0) ? 3'd0 : cur - 3'd1;
    if (pressed)   return up;
    else if (tick) return rise ? up : down;
    else           return cur;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational level-to-7-segment decoder
// Ports: level_i [2:0] stat level 0..5; seg_o [6:0] active-low {g,f,e,d,c,b,a}.
// Out-of-range levels (6, 7) decode to blank.
module seg7_decoder
  import tamagotchi_fsm_pkg::*;
(
  input  logic [2:0] level_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (level_i)
      3'd0: seg_o = SEG_0;
      3'd1: seg_o = SEG_1;
      3'd2: seg_o = SEG_2;
      3'd3: seg_o = SEG_3;
      3'd4: seg_o = SEG_4;
      3'd5: seg_o = SEG_5;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/tamagotchi_fsm.sv
// rtl/tamagotchi_fsm.sv - virtual pet: four saturating stats, button FSM, periodic decay
// Ports: clk; btn_reset async active-high; btn_salud/btn_energia/btn_hambre/
// btn_diversion stat buttons (rising edge = press); btn_test toggles fast decay;
// ledsign 1 = lights off; display_out one-hot selected stat; seg_display
// active-low 7-segment level of the selected stat (blank in IDLE).
module tamagotchi_fsm
  import tamagotchi_fsm_pkg::*;
#(
  parameter int unsigned DECAY_TICKS = 250_000_000,
  parameter int unsigned TEST_TICKS  = 8
) (
  input  logic       clk,
  input  logic       btn_reset,
  input  logic       btn_salud,
  input  logic       btn_energia,
  input  logic       btn_hambre,
  input  logic       btn_diversion,
  input  logic       btn_test,
  input  logic       ledsign,
  output logic [3:0] display_out,
  output logic [6:0] seg_display
);

  localparam logic [31:0] DECAY_LIM = 32'(DECAY_TICKS - 1);
  localparam logic [31:0] TEST_LIM  = 32'(TEST_TICKS - 1);

  // Button bit order: {test, diversion, hambre, energia, salud}
  logic [4:0]       btn_q, btn_prev_q, press;
  logic [3:0][2:0]  stat_q, stat_d;     // [0]=salud [1]=energia [2]=hambre [3]=diversion
  state_e           state_q, state_d;
  logic             test_q, test_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             tick;
  logic [3:0]       sel;
  logic [2:0]       shown_level;
  logic [6:0]       dec_seg;
  logic [3:0]       disp_q, disp_d;
  logic [6:0]       seg_q, seg_d;

  assign press = btn_q & ~btn_prev_q;
  assign tick  = (cnt_q == (test_q ? TEST_LIM : DECAY_LIM));

  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    sel     = 4'b0000;
    stat_d  = stat_q;
    test_d  = test_q ^ press[4];
    // Toggling test mode restarts the period so the first fast tick is a full period away.
    cnt_d   = (tick || press[4]) ? 32'd0 : cnt_q + 32'd1;

    if (press[0]) begin
      sel = 4'b0001; state_d = ST_SALUD;
    end else if (press[1]) begin
      sel = 4'b0010; state_d = ST_ENERGIA;
    end else if (press[2]) begin
      sel = 4'b0100; state_d = ST_HAMBRE;
    end else if (press[3]) begin
      sel = 4'b1000; state_d = ST_DIVERSION;
    end

    stat_d[0] = next_level(stat_q[0], sel[0], tick, 1'b0);
    stat_d[1] = next_level(stat_q[1], sel[1], tick, ledsign);  // sleeping restores energy
    stat_d[2] = next_level(stat_q[2], sel[2], tick, 1'b0);
    stat_d[3] = next_level(stat_q[3], sel[3], tick, 1'b0);
  end

  // Output mux works from the already-updated registers, hence the extra cycle.
  always_comb begin
    disp_d      = DISP_IDLE;
    shown_level = 3'd0;
    case (state_q)
      ST_SALUD:     begin disp_d = DISP_SALUD;     shown_level = stat_q[0]; end
      ST_ENERGIA:   begin disp_d = DISP_ENERGIA;   shown_level = stat_q[1]; end
      ST_HAMBRE:    begin disp_d = DISP_HAMBRE;    shown_level = stat_q[2]; end
      ST_DIVERSION: begin disp_d = DISP_DIVERSION; shown_level = stat_q[3]; end
      default:      begin disp_d = DISP_IDLE;      shown_level = 3'd0;      end
    endcase
    seg_d = (state_q == ST_IDLE) ? SEG_BLANK : dec_seg;
  end

  seg7_decoder u_seg7 (
    .level_i (shown_level),
    .seg_o   (dec_seg)
  );

  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset) begin
      btn_q      <= 5'b0;
      btn_prev_q <= 5'b0;
      stat_q     <= {4{RESET_LEVEL}};
      test_q     <= 1'b0;
      cnt_q      <= 32'd0;
      disp_q     <= DISP_IDLE;
      seg_q      <= SEG_BLANK;
    end else begin
      btn_q      <= {btn_test, btn_diversion, btn_hambre, btn_energia, btn_salud};
      btn_prev_q <= btn_q;
      stat_q     <= stat_d;
      test_q     <= test_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      seg_q      <= seg_d;
    end
  end

  assign display_out = disp_q;
  assign seg_display = seg_q;

endmodule

// File: tb/tb_tamagotchi_fsm.sv
// tb/tb_tamagotchi_fsm.sv - self-checking bench for tamagotchi_fsm
module tb_tamagotchi_fsm;

  logic       clk = 1'b0;
  logic       btn_reset = 1'b1;
  logic       btn_salud = 1'b0, btn_energia = 1'b0, btn_hambre = 1'b0, btn_diversion = 1'b0;
  logic       btn_test = 1'b0, ledsign = 1'b0;
  logic [3:0] display_out;
  logic [6:0] seg_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, SB = 7'b1111111;

  tamagotchi_fsm #(.DECAY_TICKS(5000), .TEST_TICKS(8)) dut (
    .clk           (clk),
    .btn_reset     (btn_reset),
    .btn_salud     (btn_salud),
    .btn_energia   (btn_energia),
    .btn_hambre    (btn_hambre),
    .btn_diversion (btn_diversion),
    .btn_test      (btn_test),
    .ledsign       (ledsign),
    .display_out   (display_out),
    .seg_display   (seg_display)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btns;   // {diversion, hambre, energia, salud}
    logic [3:0] disp;
    logic [6:0] seg;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] disp;
    logic [6:0] seg;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[13];
  int   checks = 0;
  int   errors = 0;

  task automatic push_exp(input string n, input logic [3:0] d, input logic [6:0] s);
    exp_t e;
    e.name = n; e.disp = d; e.seg = s;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: no expectation queued");
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (display_out !== e.disp) begin
        errors++;
        $display("FAIL %s display_out: got %b want %b", e.name, display_out, e.disp);
      end
      checks++;
      if (seg_display !== e.seg) begin
        errors++;
        $display("FAIL %s seg_display: got %b want %b", e.name, seg_display, e.seg);
      end
    end
  endtask

  task automatic set_btns(input logic [3:0] b);
    btn_salud = b[0]; btn_energia = b[1]; btn_hambre = b[2]; btn_diversion = b[3];
  endtask

  // One-cycle pulse driven at a falling edge; returns at the falling edge
  // after the registered outputs have updated (30 ns after the rise).
  task automatic pulse(input logic [3:0] b);
    @(negedge clk); set_btns(b);
    @(negedge clk); set_btns(4'b0000);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_test();
    @(negedge clk); btn_test = 1'b1;
    @(negedge clk); btn_test = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); btn_reset = 1'b1;
    @(negedge clk); btn_reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 4'b0001, S4};  // salud 3->4
    vecs[1]  = '{4'b0001, 4'b0001, S5};  // salud 4->5
    vecs[2]  = '{4'b0001, 4'b0001, S5};  // saturates at 5
    vecs[3]  = '{4'b1000, 4'b1000, S4};  // diversion 3->4
    vecs[4]  = '{4'b1000, 4'b1000, S5};  // diversion 4->5
    vecs[5]  = '{4'b0101, 4'b0001, S5};  // salud beats hambre
    vecs[6]  = '{4'b0010, 4'b0010, S4};  // energia 3->4
    vecs[7]  = '{4'b0100, 4'b0100, S4};  // hambre untouched by vec 5: 3->4
    vecs[8]  = '{4'b1010, 4'b0010, S5};  // energia beats diversion
    vecs[9]  = '{4'b1111, 4'b0001, S5};  // salud beats all
    vecs[10] = '{4'b1100, 4'b0100, S5};  // hambre beats diversion
    vecs[11] = '{4'b1000, 4'b1000, S5};  // diversion still 5
    vecs[12] = '{4'b0000, 4'b1000, S5};  // no press: hold

    repeat (2) @(negedge clk);
    push_exp("reset_state", 4'b0000, SB);
    pop_check();
    btn_reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      push_exp($sformatf("vec%0d", i), vecs[i].disp, vecs[i].seg);
      pulse(vecs[i].btns);
      pop_check();
    end

    // Held button counts once
    do_reset();
    push_exp("held_once", 4'b0001, S4);
    @(negedge clk); btn_salud = 1'b1;
    repeat (10) @(negedge clk);
    btn_salud = 1'b0;
    repeat (3) @(negedge clk);
    pop_check();
    push_exp("after_held", 4'b0001, S5);
    pulse(4'b0001);
    pop_check();

    // Test-mode decay and sleep recovery
    do_reset();
    push_exp("energia_sel", 4'b0010, S4);
    pulse(4'b0010);
    pop_check();
    ledsign = 1'b1;
    pulse_test();
    push_exp("sleep_recover", 4'b0010, S5);
    repeat (60) @(negedge clk);
    pop_check();
    ledsign = 1'b0;
    push_exp("decay_to_0", 4'b0010, S0);
    repeat (60) @(negedge clk);
    pop_check();
    push_exp("stays_0", 4'b0010, S0);
    repeat (30) @(negedge clk);
    pop_check();
    push_exp("salud_decayed", 4'b0001, S1);
    pulse(4'b0001);
    pop_check();
    pulse_test();  // back to normal mode: no tick for 5000 cycles
    push_exp("energia_0_to_1", 4'b0010, S1);
    pulse(4'b0010);
    pop_check();
    push_exp("normal_no_decay", 4'b0010, S1);
    repeat (100) @(negedge clk);
    pop_check();

    // Reset mid-operation with a press in flight
    @(negedge clk); btn_salud = 1'b1;
    @(negedge clk); btn_salud = 1'b0; btn_reset = 1'b1;
    #1;
    push_exp("async_reset", 4'b0000, SB);
    pop_check();
    @(negedge clk); btn_reset = 1'b0;
    push_exp("press_discarded", 4'b0000, SB);
    repeat (5) @(negedge clk);
    pop_check();
    push_exp("rs_salud", 4'b0001, S4);     pulse(4'b0001); pop_check();
    push_exp("rs_energia", 4'b0010, S4);   pulse(4'b0010); pop_check();
    push_exp("rs_hambre", 4'b0100, S4);    pulse(4'b0100); pop_check();
    push_exp("rs_diversion", 4'b1000, S4); pulse(4'b1000); pop_check();

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d want 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
